// File: rtl/dag2_result_fifo.sv
// dag2_result_fifo
// Captures the results of a fixed-latency DAG2 stage into a small
// first-word-fall-through FIFO. The operand-valid strobe is delayed by
// LATENCY cycles so that it lines up with the stage's result bus. That
// delayed strobe becomes the push request.
// Results that arrive while the FIFO is full and not draining are dropped.
// A dropped result raises a sticky overflow flag.
module dag2_result_fifo #(
  parameter int BITS    = 2,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       src_valid,
  input  logic [BITS-1:0]            res0,
  input  logic                       res1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITS:0]              out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic [7:0]                 accept_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Valid strobe delay line. Bit LATENCY-1 is the push request.
  logic [LATENCY-1:0] r_vld_sr;

  // Storage is left unreset. Only entries behind the read pointer are ever observed.
  logic [BITS:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [LW-1:0]      r_level;
  logic               r_ovf;
  logic [7:0]         r_acc_cnt;

  logic               w_push_req;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_wr_en;
  logic               w_drop;

  assign w_push_req = r_vld_sr[LATENCY-1];
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_empty    = (r_level == LW'(0));

  // A pop is only a real pop when something is held. out_ready on an empty FIFO is ignored.
  assign w_pop      = ~w_empty & out_ready;

  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign w_wr_en    = w_push_req & (~w_full | w_pop) & ~reset;
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Delay the operand-valid strobe so that it lines up with the result bus.
  // Reset empties the line, so strobes in flight (and one raised during reset) are lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= src_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
    end
  end

  // Write the result present on the bus in the cycle that push_req is high.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= {res1, res0};
    end
  end

  // Pointer maintenance. DEPTH is a power of two, so natural wrap gives modulo-DEPTH order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  // Occupancy. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow. A drop in the same cycle wins over clear_ovf.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // Count of results actually written. It wraps naturally at 256.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc_cnt <= 8'd0;
    end else if (w_wr_en) begin
      r_acc_cnt <= r_acc_cnt + 8'd1;
    end else begin
      r_acc_cnt <= r_acc_cnt;
    end
  end

  // The head entry falls through from storage. It is decoded only from registered state.
  assign out_valid    = ~w_empty;
  assign out_data     = r_mem[r_rptr];
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign accept_count = r_acc_cnt;

endmodule

// File: tb/tb_dag2_result_fifo.sv
// Testbench for dag2_result_fifo.
// A queue-based reference model tracks the expected FIFO contents and flags.
// On every falling edge the bench compares the DUT outputs against that model.
// Directed scenarios add fixed-value checks at the points of interest.
module tb_dag2_result_fifo;

  localparam int BITS  = 2;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            src_valid = 1'b0;
  logic [BITS-1:0] res0 = '0;
  logic            res1 = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS:0]   out_data;
  logic [2:0]      level;
  logic            overflow;
  logic            clear_ovf = 1'b0;
  logic [7:0]      accept_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [BITS:0]   q_exp [$];
  logic [LAT-1:0]  m_sr = '0;
  logic            m_ovf = 1'b0;
  logic [7:0]      m_cnt = 8'd0;
  bit              started = 1'b0;

  // Driver-side delay line. It places each operand's result on res0/res1 LAT cycles later.
  logic [BITS:0]   dl [LAT];

  dag2_result_fifo #(.BITS(BITS), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .src_valid    (src_valid),
    .res0         (res0),
    .res1         (res1),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .accept_count (accept_count)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: updates on each rising edge from the bench-driven inputs.
  initial begin
    bit pop;
    bit full;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_sr = '0;
        q_exp.delete();
        m_ovf = 1'b0;
        m_cnt = 8'd0;
        started = 1'b1;
      end else begin
        pop  = (q_exp.size() != 0) && out_ready;
        full = (q_exp.size() == DEPTH);
        if (pop) void'(q_exp.pop_front());
        if (m_sr[LAT-1]) begin
          if (!full || pop) begin
            q_exp.push_back({res1, res0});
            m_cnt = m_cnt + 8'd1;
          end else begin
            m_ovf = 1'b1;
          end
        end else if (clear_ovf) begin
          m_ovf = 1'b0;
        end
        m_sr = {m_sr[LAT-2:0], src_valid};
      end
    end
  end

  // Per-cycle scoreboard comparison on the falling edge.
  initial forever begin
    @(negedge clock);
    if (started) begin
      check("valid", {31'd0, out_valid}, (q_exp.size() != 0) ? 32'd1 : 32'd0);
      check("level", {29'd0, level}, q_exp.size());
      check("ovf",   {31'd0, overflow}, {31'd0, m_ovf});
      check("count", {24'd0, accept_count}, {24'd0, m_cnt});
      if (q_exp.size() != 0) check("head", {29'd0, out_data}, {29'd0, q_exp[0]});
    end
  end

  task automatic step(input logic sv, input logic [BITS:0] val, input logic rdy, input logic clr);
    @(posedge clock); #1;
    src_valid = sv;
    out_ready = rdy;
    clear_ovf = clr;
    {res1, res0} = dl[LAT-1];
    for (int i = LAT-1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = sv ? val : 3'($urandom);
  endtask

  // Hold reset for n cycles, with src_valid asserted during reset to show that it is discarded.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      reset = 1'b1;
      src_valid = 1'b1;
      out_ready = 1'b1;
      clear_ovf = 1'b0;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    src_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) dl[i] = 3'd0;

    // Reset state.
    do_reset(2);
    @(negedge clock);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_count", {24'd0, accept_count}, 32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);

    // Single result: it is visible after the edge that ends the push_req cycle.
    step(1'b1, 3'b110, 1'b0, 1'b0);
    repeat (4) step(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("one_valid", {31'd0, out_valid}, 32'd1);
    check("one_data",  {29'd0, out_data}, 32'd6);
    check("one_level", {29'd0, level}, 32'd1);
    check("one_count", {24'd0, accept_count}, 32'd1);

    // Six pulses with no drain: four are stored, two are dropped.
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b1, 3'(i), 1'b0, 1'b0);
    repeat (4) step(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("ovf_level", {29'd0, level}, 32'd4);
    check("ovf_flag",  {31'd0, overflow}, 32'd1);
    check("ovf_count", {24'd0, accept_count}, 32'd4);
    check("ovf_head",  {29'd0, out_data}, 32'd0);

    // A clear in the same cycle as a new drop leaves the flag set.
    step(1'b1, 3'd7, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("clr_drop", {31'd0, overflow}, 32'd1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("clr_ok", {31'd0, overflow}, 32'd0);

    // Drain: the scoreboard checks the order 0,1,2,3.
    repeat (5) step(1'b0, 3'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("drain_level", {29'd0, level}, 32'd0);

    // Full FIFO with streaming pushes and pops across pointer wrap.
    do_reset(1);
    for (int i = 0; i < 27; i++) step(1'b1, 3'($urandom), (i >= 7) ? 1'b1 : 1'b0, 1'b0);
    @(negedge clock);
    check("stream_level", {29'd0, level}, 32'd4);
    check("stream_ovf",   {31'd0, overflow}, 32'd0);
    repeat (8) step(1'b0, 3'd0, 1'b1, 1'b0);

    // Push into an empty FIFO while out_ready is high.
    do_reset(1);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    repeat (4) step(1'b0, 3'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("empty_rdy_level", {29'd0, level}, 32'd1);
    check("empty_rdy_data",  {29'd0, out_data}, 32'd5);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("empty_rdy_pop", {29'd0, level}, 32'd0);

    // A pulse in flight when reset arrives is discarded.
    do_reset(1);
    step(1'b1, 3'd3, 1'b0, 1'b0);
    do_reset(1);
    repeat (4) step(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("flight_level", {29'd0, level}, 32'd0);
    check("flight_count", {24'd0, accept_count}, 32'd0);

    // accept_count wraps: 259 accepted results leave 3.
    do_reset(1);
    repeat (259) step(1'b1, 3'($urandom), 1'b1, 1'b0);
    repeat (6) step(1'b0, 3'd0, 1'b1, 1'b0);
    @(negedge clock);
    check("wrap_count", {24'd0, accept_count}, 32'd3);
    check("wrap_level", {29'd0, level}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dag2_result_fifo.md
DAG2_RESULT_FIFO -- requirements
Module: dag2_result_fifo

Interface
REQ-001 Parameter: BITS, 2, width of the multi-bit result lane.
REQ-002 Parameter: LATENCY, 3, clock cycles from operand launch into the DAG2 stage to its result appearing on res0/res1.
REQ-003 Parameter: DEPTH, 4, FIFO entries; power of two, minimum 2.
REQ-004 Port: clock  input  1  single rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-006 Port: src_valid  input  1  high in the cycle a valid operand set enters the DAG2 stage.
REQ-007 Port: res0  input  BITS  DAG2 multi-bit result (out0 of the upstream stage).
REQ-008 Port: res1  input  1  DAG2 single-bit result (out1 of the upstream stage).
REQ-009 Port: out_valid  output  1  FIFO holds at least one entry.
REQ-010 Port: out_ready  input  1  consumer accepts the head entry this cycle.
REQ-011 Port: out_data  output  BITS+1  head entry, {res1, res0}.
REQ-012 Port: level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 Port: overflow  output  1  sticky flag: a result was dropped because the FIFO was full.
REQ-014 Port: clear_ovf  input  1  clears overflow.
REQ-015 Port: accept_count  output  8  number of results written into the FIFO, modulo 256.

Function
REQ-016 The block SHALL delay src_valid through a LATENCY-stage shift register, producing push_req.
REQ-017 src_valid high in cycle t SHALL produce push_req high in cycle t+LATENCY, and {res1,res0} sampled in cycle t+LATENCY SHALL be the entry written.
REQ-018 Back-to-back src_valid SHALL yield back-to-back pushes; no bubble is inserted.
REQ-019 pop SHALL equal out_valid AND out_ready; out_ready while empty SHALL have no effect.
REQ-020 out_data SHALL present the oldest entry from registered storage, with no extra read latency (first-word fall-through); its value SHALL be don't-care while out_valid is low.
REQ-021 push_req while level < DEPTH SHALL write the entry, increment the write pointer, and increment accept_count.
REQ-022 push_req and pop in the same cycle while level == DEPTH SHALL both take effect; level SHALL stay DEPTH and no overflow SHALL be flagged.
REQ-023 push_req while level == DEPTH with no pop SHALL drop the entry, set overflow on the next edge, and leave accept_count, pointers and storage unchanged.
REQ-024 push_req and out_ready in the same cycle while level == 0 SHALL write the entry with no pop; level SHALL become 1.
REQ-025 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-026 level SHALL update on the edge: +1 for push only, -1 for pop only, unchanged for both or neither.
REQ-027 accept_count SHALL wrap from 255 to 0.
REQ-028 clear_ovf SHALL clear overflow on the next edge; if a drop occurs in the same cycle, set SHALL take priority and overflow SHALL remain 1.
REQ-029 All outputs SHALL be driven from registers, except out_valid and out_data, which are decoded from registered state only, with no input-to-output combinational path.

Reset
REQ-030 While reset is high at an edge, the block SHALL clear the shift register, both pointers, level, overflow and accept_count; out_valid SHALL read 0 after that edge.
REQ-031 Reset SHALL take priority over push, pop and clear_ovf in the same cycle.
REQ-032 src_valid pulses in flight at reset SHALL be discarded and never pushed, including pulses asserted during the reset cycle.
REQ-033 Storage contents need not be cleared by reset.

Verification
REQ-034 Reset, then src_valid for 1 cycle at t=0 with res0=2'b10, res1=1 at t=3 -> out_valid rises after the t=3 edge, out_data=3'b110, level=1, accept_count=1.
REQ-035 Six consecutive src_valid pulses, out_ready=0, results 0..5 -> entries 0..3 stored, level=4, overflow=1, accept_count=4; draining yields 0,1,2,3 in order.
REQ-036 FIFO full, out_ready=1 held and continuous pushes -> level stays 4, overflow stays 0, output order is preserved across pointer wrap.
REQ-037 Empty FIFO, push_req and out_ready in the same cycle -> level=1, and the entry is read out on the following handshake.
REQ-038 Overflow set, then clear_ovf in a cycle with a new drop -> overflow stays 1; clear_ovf in a later cycle with no drop -> overflow=0.
REQ-039 src_valid at t=0, reset at t=1 -> nothing is pushed at t=3, level=0, accept_count=0.
